// File: rtl/sos_gain_shift_pipe.sv
// sos_gain_shift_pipe
//   Pipelined coefficient gain-and-shift for one SOS tap:
//   P = sat(round((X * H) >>> SHIFT_NUM)), with valid/ready handshaking and
//   overflow monitoring for IIR stability checks.
//   The multiply result is carried through the first PIPE_STG-1 stages.
//   Rounding and saturation are done in the final, registered stage.
//   The whole pipeline advances only when the output slot is free or being drained.
//
// Ports
//   CLK         rising-edge clock
//   RST_N       asynchronous active-low reset
//   IN_VLD      X/H valid
//   IN_RDY      block can accept this cycle (combinational)
//   X           signed sample, IIR_WD bits
//   H           signed coefficient, COF_WD bits
//   OUT_VLD     P valid
//   OUT_RDY     downstream accepts P
//   P           signed scaled product, IIR_WD bits
//   OVF         range overflow of the current P (qualified by OUT_VLD)
//   OVF_STICKY  set by any emitted overflow; held until OVF_CLR
//   OVF_CLR     synchronous clear of OVF_STICKY and OVF_CNT
//   OVF_CNT     saturating count of emitted overflowed samples
module sos_gain_shift_pipe #(
    parameter int IIR_WD    = 48,
    parameter int COF_WD    = 32,
    parameter int SHIFT_NUM = 30,
    parameter int PIPE_STG  = 3,
    parameter int ROUND_EN  = 1,
    parameter int SAT_EN    = 1,
    parameter int CNT_WD    = 16
) (
    input  logic                     CLK,
    input  logic                     RST_N,
    input  logic                     IN_VLD,
    output logic                     IN_RDY,
    input  logic signed [IIR_WD-1:0] X,
    input  logic signed [COF_WD-1:0] H,
    output logic                     OUT_VLD,
    input  logic                     OUT_RDY,
    output logic signed [IIR_WD-1:0] P,
    output logic                     OVF,
    output logic                     OVF_STICKY,
    input  logic                     OVF_CLR,
    output logic [CNT_WD-1:0]        OVF_CNT
);

    localparam int PW     = IIR_WD + COF_WD;   // full product width
    localparam int EW     = PW + 1;            // one guard bit so the rounding add cannot carry out
    localparam int RND_SH = (SHIFT_NUM > 0) ? SHIFT_NUM - 1 : 0;
    localparam logic signed [EW-1:0] RND_ADD =
        (ROUND_EN != 0 && SHIFT_NUM > 0) ? ({{(EW-1){1'b0}}, 1'b1} << RND_SH) : '0;

    function automatic logic signed [PW-1:0] mul_full(input logic signed [IIR_WD-1:0] a,
                                                      input logic signed [COF_WD-1:0] b);
        logic signed [PW-1:0] ae;
        logic signed [PW-1:0] be;
        ae = PW'(a);
        be = PW'(b);
        return ae * be;
    endfunction

    // Round-half-up then arithmetic shift; floor after +0.5 gives -1.5 -> -1, +1.5 -> +2.
    function automatic logic signed [EW-1:0] round_shift(input logic signed [PW-1:0] prod);
        logic signed [EW-1:0] ext;
        ext = EW'(prod) + RND_ADD;
        return ext >>> SHIFT_NUM;
    endfunction

    // Returns {ovf, p}. The value fits only when all bits from the IIR_WD-1 position up are copies of the sign.
    function automatic logic [IIR_WD:0] saturate(input logic signed [EW-1:0] v);
        logic              ovf;
        logic [IIR_WD-1:0] p;
        ovf = ~((&v[EW-1:IIR_WD-1]) | (~|v[EW-1:IIR_WD-1]));
        if (ovf && SAT_EN != 0)
            p = v[EW-1] ? {1'b1, {(IIR_WD-1){1'b0}}} : {1'b0, {(IIR_WD-1){1'b1}}};
        else
            p = v[IIR_WD-1:0];
        return {ovf, p};
    endfunction

    logic en;
    assign en     = OUT_RDY | ~OUT_VLD;
    assign IN_RDY = en;

    logic signed [PW-1:0] last_prod;
    logic                 last_vld;

    if (PIPE_STG == 1) begin : g_direct
        assign last_prod = mul_full(X, H);
        assign last_vld  = IN_VLD;
    end else begin : g_mul_pipe
        logic signed [PW-1:0] prod_p [PIPE_STG-1];
        logic                 vld_p  [PIPE_STG-1];

        // ---- stages 0..PIPE_STG-2: product and its valid shift together ----
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                for (int i = 0; i < PIPE_STG-1; i++) vld_p[i] <= 1'b0;
            end else if (en) begin
                vld_p[0] <= IN_VLD;
                for (int i = 1; i < PIPE_STG-1; i++) vld_p[i] <= vld_p[i-1];
            end
        end

        always_ff @(posedge CLK) begin
            if (en) begin
                prod_p[0] <= mul_full(X, H);
                for (int i = 1; i < PIPE_STG-1; i++) prod_p[i] <= prod_p[i-1];
            end
        end

        assign last_prod = prod_p[PIPE_STG-2];
        assign last_vld  = vld_p[PIPE_STG-2];
    end

    logic [IIR_WD:0] sat_res;
    assign sat_res = saturate(round_shift(last_prod));

    // ---- final stage: rounded/saturated output register ----
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OUT_VLD <= 1'b0;
            P       <= '0;
            OVF     <= 1'b0;
        end else if (en) begin
            OUT_VLD <= last_vld;
            P       <= sat_res[IIR_WD-1:0];
            OVF     <= sat_res[IIR_WD] & last_vld;
        end
    end

    // Overflow monitor counts only samples actually taken by the consumer.
    logic              ovf_evt;
    logic [CNT_WD-1:0] cnt_base;
    assign ovf_evt  = OUT_VLD & OUT_RDY & OVF;
    assign cnt_base = OVF_CLR ? '0 : OVF_CNT;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            OVF_STICKY <= 1'b0;
            OVF_CNT    <= '0;
        end else begin
            OVF_STICKY <= (~OVF_CLR & OVF_STICKY) | ovf_evt;
            if (ovf_evt && !(&cnt_base))
                OVF_CNT <= cnt_base + CNT_WD'(1);
            else
                OVF_CNT <= cnt_base;
        end
    end

endmodule
